decode_stage: RTL
=================

Name: decode_stage

Overview:
- Pipeline stage directly upstream of register_file.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and drives the register_file read addresses.
- Merges read data with a writeback bypass, then presents decoded operands to execute.
- Keeps an 8-entry busy scoreboard so an instruction never issues on a stale operand or over a pending write.

Parameters:
- DW, 32, data and instruction width
- AW, 3, register address width (8 registers)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  decode can accept this cycle
- in_instr  in  DW  instruction word
- flush  in  1  discard all held instructions
- rf_ra1  out  AW  register_file read address 1 (rs)
- rf_ra2  out  AW  register_file read address 2 (rt)
- rf_rd1  in  DW  register_file read data 1 (combinational)
- rf_rd2  in  DW  register_file read data 2 (combinational)
- wb_we  in  1  writeback writes this cycle
- wb_wa  in  AW  writeback address
- wb_wd  in  DW  writeback data
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_op  out  6  opcode
- out_a  out  DW  rs operand
- out_b  out  DW  rt operand
- out_imm  out  DW  sign-extended imm
- out_wa  out  AW  destination (rd)
- out_we  out  1  instruction writes rd

Behaviour:
- Reset (rst low, asynchronous): ir_valid=0, out_valid=0, busy=8'h00, all out_* = 0, rf_ra1/rf_ra2 = 0. in_ready forced to 0 while rst is low.
- Instruction format:
  - [31:26] op
  - [25:23] rs
  - [22:20] rt
  - [19:17] rd
  - [15:0] imm, sign-extended to DW
- rf_ra1 = IR.rs, rf_ra2 = IR.rt, driven combinationally from the instruction register.
- Writes-rd: op in {ADD, SUB, AND, OR, ADDI, LW}. All others have out_we=0.
- Bypass: operand = wb_wd when wb_we && wb_wa == the source address; otherwise rf_rd*.
- Hazard, all evaluated combinationally:
  - eff_busy = busy & ~(wb_we ? onehot(wb_wa) : 0).
  - stall if eff_busy[rs] or eff_busy[rt].
  - stall if writes-rd and eff_busy[rd] (WAW).
  - Register 0 is an ordinary register, with no special case.
- issue = ir_valid && !stall && (!out_valid || out_ready) && !flush.
- in_ready = rst && (!ir_valid || issue) && !flush.
- Per clock edge:
  - in_valid && in_ready: IR <= in_instr, ir_valid <= 1.
  - Else if issue: ir_valid <= 0.
  - issue: the output register loads op/a/b/imm/wa/we and out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - issue && writes-rd: busy[rd] <= 1.
  - wb_we: busy[wb_wa] <= 0.
  - Set and clear on the same address in the same cycle: set wins.
- Latency: an accepted instruction appears on out_* on the next edge when there is no hazard (1 cycle in IR). Throughput is 1 per cycle with no hazards.
- Output hold: out_* are stable while out_valid && !out_ready.
- Flush has priority over accept, issue and writeback set. On flush:
  - ir_valid <= 0 and out_valid <= 0.
  - If out_valid && out_we, busy[out_wa] <= 0, since that instruction was never consumed.
  - Writebacks in the same cycle still clear busy.
- Reset mid-operation: immediate return to reset state. The pending busy bits are lost, and execute/writeback must be reset together with this stage.

Decomposition:
- Package cpu_pkg:
  - opcode constants OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_ADDI=5, OP_LW=6, OP_SW=7, OP_BEQ=8
  - field bit positions
  - writes_rd function
- Sub-module hazard_scoreboard: owns the busy bitmap, set/clear/flush-clear logic and the stall output.

Test Plan:
- Reset pulse low for 10 ns, then send ADD rs=1 rt=2 rd=3 with RF r1=32'h11111111, r2=32'h22222222 -> out_valid one edge after accept, out_a=32'h11111111, out_b=32'h22222222, out_wa=3, out_we=1, busy[3]=1.
- ADD rd=3, then ADD rs=3 rt=0 -> second instruction stalls (in_ready=0, out_valid drops after first consumed). Drive wb_we=1 wb_wa=3 wb_wd=32'haaaaaaaa -> issues that cycle with out_a=32'haaaaaaaa via bypass.
- ADDI with imm=16'hFFFE -> out_imm=32'hFFFFFFFE, out_we=1. SW -> out_we=0 and busy unchanged.
- Hold out_ready=0 for 3 cycles with two instructions queued -> out_* stable, in_ready=0 once IR is full, no instruction lost or duplicated after release.
- Flush while out_valid with out_wa=5, out_we=1, and IR full -> next cycle out_valid=0, ir_valid=0, busy[5]=0. Flush with in_valid=1 in the same cycle -> instruction not accepted.
- Assert rst low while busy=8'h18 and out_valid=1 -> out_valid=0, busy=0 and in_ready=0 immediately (asynchronously, before the next edge).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, instruction field
// layout and the helper that says which opcodes write a destination register.
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;
    localparam logic [5:0] OP_LW   = 6'd6;
    localparam logic [5:0] OP_SW   = 6'd7;
    localparam logic [5:0] OP_BEQ  = 6'd8;

    localparam int OP_LSB  = 26;
    localparam int RS_LSB  = 23;
    localparam int RT_LSB  = 20;
    localparam int RD_LSB  = 17;
    localparam int IMM_LSB = 0;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 16;

    typedef struct packed {
        logic [5:0]       op;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
    } instr_t;

    function automatic instr_t decode_instr(input logic [31:0] w);
        instr_t f;
        f.op  = w[OP_LSB  +: 6];
        f.rs  = w[RS_LSB  +: REG_W];
        f.rt  = w[RT_LSB  +: REG_W];
        f.rd  = w[RD_LSB  +: REG_W];
        f.imm = w[IMM_LSB +: IMM_W];
        return f;
    endfunction

    function automatic logic writes_rd(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW: writes_rd = 1'b1;
            default:                                       writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy bitmap for registers with an issued-but-not-written-back result;
// produces the RAW/WAW stall for the instruction held in decode.
module hazard_scoreboard #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rt_i,
    input  logic [AW-1:0] rd_i,
    input  logic          chk_we_i,
    input  logic          set_i,
    input  logic [AW-1:0] set_wa_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_wa_i,
    input  logic          flush_i,
    input  logic          flush_clr_i,
    input  logic [AW-1:0] flush_wa_i,
    output logic          stall_o
);

    localparam int NR = 1 << AW;

    logic [NR-1:0] busy_q, busy_d;
    logic [NR-1:0] wb_mask;
    logic [NR-1:0] eff_busy;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wb_mask = '0;
        if (wb_we_i) wb_mask[wb_wa_i] = 1'b1;
        eff_busy = busy_q & ~wb_mask;
        stall_o  = eff_busy[rs_i] | eff_busy[rt_i] | (chk_we_i & eff_busy[rd_i]);
    end

    // A set applied after the writeback clear lets a same-address set win.
    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (flush_i) begin
            if (flush_clr_i) busy_d[flush_wa_i] = 1'b0;
        end else if (set_i) begin
            busy_d[set_wa_i] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: holds one instruction, reads the register file with a
// writeback bypass, and issues to execute once the scoreboard clears it.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_instr,
    input  logic          flush,
    output logic [AW-1:0] rf_ra1,
    output logic [AW-1:0] rf_ra2,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_wa,
    input  logic [DW-1:0] wb_wd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    out_op,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic [DW-1:0] out_imm,
    output logic [AW-1:0] out_wa,
    output logic          out_we
);

    instr_t        ir_q;
    logic          ir_valid_q;
    logic          out_valid_q;
    logic [5:0]    op_q;
    logic [DW-1:0] a_q, b_q, imm_q;
    logic [AW-1:0] wa_q;
    logic          we_q;

    logic          ir_we;
    logic          stall;
    logic          issue;
    logic          accept;
    logic [DW-1:0] opnd_a, opnd_b, imm_ext;
    logic          unused_instr_bits;

    assign unused_instr_bits = in_instr[16];

    assign rf_ra1  = ir_q.rs;
    assign rf_ra2  = ir_q.rt;
    assign ir_we   = writes_rd(ir_q.op);
    assign opnd_a  = (wb_we && wb_wa == ir_q.rs) ? wb_wd : rf_rd1;
    assign opnd_b  = (wb_we && wb_wa == ir_q.rt) ? wb_wd : rf_rd2;
    assign imm_ext = {{(DW-IMM_W){ir_q.imm[IMM_W-1]}}, ir_q.imm};

    assign issue    = ir_valid_q && !stall && (!out_valid_q || out_ready) && !flush;
    assign in_ready = rst && (!ir_valid_q || issue) && !flush;
    assign accept   = in_valid && in_ready;

    hazard_scoreboard #(.AW(AW)) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .rs_i        (ir_q.rs),
        .rt_i        (ir_q.rt),
        .rd_i        (ir_q.rd),
        .chk_we_i    (ir_we),
        .set_i       (issue && ir_we),
        .set_wa_i    (ir_q.rd),
        .wb_we_i     (wb_we),
        .wb_wa_i     (wb_wa),
        .flush_i     (flush),
        .flush_clr_i (out_valid_q && we_q),
        .flush_wa_i  (wa_q),
        .stall_o     (stall)
    );

    // NOTE: the instruction and output registers are reset too, so rf_ra*/out_* are defined zeros in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            wa_q        <= '0;
            we_q        <= 1'b0;
        end else if (flush) begin
            ir_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                ir_q       <= decode_instr(in_instr[31:0]);
                ir_valid_q <= 1'b1;
            end else if (issue) begin
                ir_valid_q <= 1'b0;
            end

            if (issue) begin
                op_q        <= ir_q.op;
                a_q         <= opnd_a;
                b_q         <= opnd_b;
                imm_q       <= imm_ext;
                wa_q        <= ir_q.rd;
                we_q        <= ir_we;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = op_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_imm   = imm_q;
    assign out_wa    = wa_q;
    assign out_we    = we_q;

endmodule
